// File: rtl/kmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module : kmul_pkg
//  Brief  : Shared types, widths and the round-robin pick helper for the
//           Karatsuba multiplier scheduler.
//  Rev    : 1.0  initial release
// ============================================================================
package kmul_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } kmul_sched_state_e;

    localparam int LOGQ_DEF = 64;
    localparam int OPW      = LOGQ_DEF / 2;
    localparam int RESW     = LOGQ_DEF;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } rr_pick_t;

    // Scans ptr+1, ptr+2, ... modulo n (n <= 8) and returns the first valid index.
    function automatic rr_pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 1; k <= 8; k++) begin
            j = (int'(ptr) + k) % n;
            if (k <= n && !r.hit && valid[3'(j)]) begin
                r.hit = 1'b1;
                r.idx = 3'(j);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kmul_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module : kmul_rr_scheduler_if
//  Brief  : Requester, multiplier, result and flush signals of the scheduler.
//  Rev    : 1.0  initial release
// ============================================================================
interface kmul_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LOGQ    = 64,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*(LOGQ/2)-1:0]   req_a;
    logic [NUM_REQ*(LOGQ/2)-1:0]   req_b;
    logic [LOGQ/2-1:0]             mul_a;
    logic [LOGQ/2-1:0]             mul_b;
    logic [LOGQ-1:0]               mul_c;
    logic                          res_valid;
    logic [ID_W-1:0]               res_id;
    logic [LOGQ-1:0]               res_c;
    logic                          flush_req;
    logic                          flush_done;
    logic                          busy;

    modport master (
        output req_valid, req_a, req_b, mul_c, flush_req,
        input  req_ready, mul_a, mul_b, res_valid, res_id, res_c, flush_done, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_c, flush_req,
        output req_ready, mul_a, mul_b, res_valid, res_id, res_c, flush_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/kmul_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module : kmul_tag_pipe
//  Brief  : Valid+ID shift register that tracks ops through the multiplier.
//  Rev    : 1.0  initial release
// ============================================================================
module kmul_tag_pipe #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic            any_valid
);
    logic [DEPTH-1:0] vld;
    logic [ID_W-1:0]  ids [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) ids[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            ids[0] <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                ids[i] <= ids[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_id    = ids[DEPTH-1];
    assign any_valid = |vld;
endmodule
`default_nettype wire

// File: rtl/kmul_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : kmul_rr_scheduler
//  Brief  : Round-robin sharing of one pipelined multiplier with tagged results
//           and a flush/drain FSM. Optional counters: KMUL_SCHED_STATS_EN.
//  Rev    : 1.0  initial release
// ============================================================================
module kmul_rr_scheduler
    import kmul_pkg::*;
#(
    parameter int LOGQ        = 64,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    kmul_rr_scheduler_if.slave        bus
`ifdef KMUL_SCHED_STATS_EN
    ,
    output logic [31:0]               stat_accepts,
    output logic [31:0]               stat_stall
`endif
);
    localparam int OP_W = LOGQ / 2;

    kmul_sched_state_e   state;
    logic [ID_W-1:0]     ptr;
    rr_pick_t            pick;
    logic                grant_en;
    logic [ID_W-1:0]     grant_id;
    logic [NUM_REQ-1:0]  ready;
    logic [OP_W-1:0]     sel_a;
    logic [OP_W-1:0]     sel_b;

    logic [OP_W-1:0]     mul_a_q;
    logic [OP_W-1:0]     mul_b_q;
    logic                issue_vld;
    logic [ID_W-1:0]     issue_id;
    logic                pipe_vld;
    logic [ID_W-1:0]     pipe_id;
    logic                pipe_any;
    logic                res_vld_q;
    logic [ID_W-1:0]     res_id_q;
    logic [LOGQ-1:0]     res_c_q;
    logic                flush_done_q;
    logic                drained;

    always_comb begin
        pick     = rr_pick(8'(bus.req_valid), 3'(ptr), NUM_REQ);
        grant_en = !rst && (state == RUN) && !bus.flush_req && pick.hit;
        grant_id = ID_W'(pick.idx);
        ready    = '0;
        if (grant_en) ready[grant_id] = 1'b1;
        sel_a    = bus.req_a[grant_id*OP_W +: OP_W];
        sel_b    = bus.req_b[grant_id*OP_W +: OP_W];
    end

    // Issue stage: the tag register sits alongside mul_a/mul_b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= ID_W'(NUM_REQ - 1);
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            issue_vld <= 1'b0;
            issue_id  <= '0;
        end else begin
            issue_vld <= grant_en;
            issue_id  <= grant_en ? grant_id : '0;
            mul_a_q   <= grant_en ? sel_a : '0;
            mul_b_q   <= grant_en ? sel_b : '0;
            if (grant_en) ptr <= grant_id;
        end
    end

    kmul_tag_pipe #(
        .DEPTH (MUL_LATENCY),
        .ID_W  (ID_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_vld),
        .in_id     (issue_id),
        .out_valid (pipe_vld),
        .out_id    (pipe_id),
        .any_valid (pipe_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_vld_q <= 1'b0;
            res_id_q  <= '0;
            res_c_q   <= '0;
        end else begin
            res_vld_q <= pipe_vld;
            if (pipe_vld) begin
                res_id_q <= pipe_id;
                res_c_q  <= bus.mul_c;
            end
        end
    end

    // Nothing left upstream of the result register, so after this edge it is empty too.
    assign drained = !issue_vld && !pipe_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.flush_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.flush_req) begin
                        state <= RUN;
                    end else if (drained) begin
                        state        <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.flush_req) begin
                        state        <= RUN;
                        flush_done_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= RUN;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef KMUL_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_accepts <= '0;
            stat_stall   <= '0;
        end else if (state == DONE && !bus.flush_req) begin
            stat_accepts <= '0;
            stat_stall   <= '0;
        end else begin
            if (grant_en) stat_accepts <= stat_accepts + 32'd1;
            if ((|bus.req_valid) && !grant_en && (state != DONE))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

    assign bus.req_ready  = ready;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.res_valid  = res_vld_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_c      = res_c_q;
    assign bus.flush_done = flush_done_q;
    assign bus.busy       = issue_vld || pipe_any;
endmodule
`default_nettype wire

// File: tb/tb_kmul_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : tb_kmul_rr_scheduler
//  Brief  : Directed vector bench with a behavioural 4-stage multiplier model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_kmul_rr_scheduler;
    logic clk;
    logic rst;

    kmul_rr_scheduler_if #(.NUM_REQ(4), .LOGQ(64), .ID_W(2)) bus ();

`ifdef KMUL_SCHED_STATS_EN
    logic [31:0] stat_accepts;
    logic [31:0] stat_stall;
`endif

    kmul_rr_scheduler #(
        .LOGQ        (64),
        .NUM_REQ     (4),
        .ID_W        (2),
        .MUL_LATENCY (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef KMUL_SCHED_STATS_EN
        ,
        .stat_accepts (stat_accepts),
        .stat_stall   (stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural multiplier: product of mul_a/mul_b valid 4 edges after they are set.
    logic [63:0] mpipe [4] = '{default: '0};
    always @(posedge clk) begin
        mpipe[0] <= 64'(bus.mul_a) * 64'(bus.mul_b);
        for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_c = mpipe[3];

    typedef struct packed {
        logic [3:0]       valid;
        logic             flush;
        logic [3:0]       exp_ready;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [63:0] c;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_res_cyc = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result scoreboard, sampled 1ns after every edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("res_valid", 64'(bus.res_valid), 64'd1);
            check("res_id", 64'(bus.res_id), 64'(exp_q[0].id));
            check("res_c", bus.res_c, exp_q[0].c);
            void'(exp_q.pop_front());
        end else begin
            check("res_valid_idle", 64'(bus.res_valid), 64'd0);
        end
    end

    function automatic vec_t mk(input logic [3:0] valid, input logic flush, input logic [3:0] exp_r,
                                input logic [31:0] ab, input logic [31:0] bb);
        vec_t v;
        v.valid     = valid;
        v.flush     = flush;
        v.exp_ready = exp_r;
        for (int i = 0; i < 4; i++) begin
            v.a[i] = ab + 32'(i);
            v.b[i] = bb + 32'(i);
        end
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.req_valid = v.valid;
        bus.flush_req = v.flush;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = v.a[i];
            bus.req_b[i*32 +: 32] = v.b[i];
        end
        #1;
        check("req_ready", 64'(bus.req_ready), 64'(v.exp_ready));
        for (int i = 0; i < 4; i++) begin
            if (v.exp_ready[i]) begin
                exp_t e;
                e.cyc = cyc + 6;
                e.id  = 2'(i);
                e.c   = 64'(v.a[i]) * 64'(v.b[i]);
                exp_q.push_back(e);
                last_res_cyc = e.cyc;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run_range(input int s, input int e);
        for (int i = s; i < e; i++) apply(vecs[i]);
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.flush_req = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_mul_a", 64'(bus.mul_a), 64'd0);
        check("rst_mul_b", 64'(bus.mul_b), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res_id", 64'(bus.res_id), 64'd0);
        check("rst_res_c", bus.res_c, 64'd0);
        check("rst_flush_done", 64'(bus.flush_done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int s1, s2, s3, s4a, s4b, s6, s5;
        logic [3:0] sp_valid [8] = '{4'b1010, 4'b0101, 4'b0000, 4'b1010, 4'b0101, 4'b0000, 4'b1010, 4'b0101};
        logic [3:0] sp_exp   [8] = '{4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0100};

        // Single op, then idle while it drains out.
        s1 = vecs.size();
        vecs.push_back(mk(4'b0001, 1'b0, 4'b0001, 32'd3, 32'd5));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 32'd0, 32'd0));
        // Fairness with all requesters valid.
        s2 = vecs.size();
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(4'b1111, 1'b0, 4'(1 << (i % 4)), 32'(100 + i * 10), 32'(7 + i)));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 32'd0, 32'd0));
        // Full width followed by zero operand.
        s3 = vecs.size();
        vecs.push_back(mk(4'b0001, 1'b0, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        vecs.push_back(mk(4'b0001, 1'b0, 4'b0001, 32'h0, 32'hFFFF_FFFF));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 32'd0, 32'd0));
        // Three accepts before a flush, then resume.
        s4a = vecs.size();
        vecs.push_back(mk(4'b1111, 1'b0, 4'b0010, 32'd200, 32'd300));
        vecs.push_back(mk(4'b1111, 1'b0, 4'b0100, 32'd210, 32'd310));
        vecs.push_back(mk(4'b1111, 1'b0, 4'b1000, 32'd220, 32'd320));
        s4b = vecs.size();
        vecs.push_back(mk(4'b1111, 1'b0, 4'b0000, 32'd230, 32'd330));
        vecs.push_back(mk(4'b1111, 1'b0, 4'b0001, 32'd240, 32'd340));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 32'd0, 32'd0));
        // Sparse alternating requesters with bubbles.
        s6 = vecs.size();
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(sp_valid[i], 1'b0, sp_exp[i], 32'(1000 + i * 16), 32'(50 + i)));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 32'd0, 32'd0));
        // Two accepts then a reset.
        s5 = vecs.size();
        vecs.push_back(mk(4'b0011, 1'b0, 4'b0001, 32'd77, 32'd88));
        vecs.push_back(mk(4'b0011, 1'b0, 4'b0010, 32'd99, 32'd66));

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.flush_req = 1'b0;
        rst           = 1'b1;
        #2;
        do_reset();

        apply(vecs[s1]);
        check("t1_mul_a", 64'(bus.mul_a), 64'd3);
        check("t1_mul_b", 64'(bus.mul_b), 64'd5);
        check("t1_busy", 64'(bus.busy), 64'd1);
        run_range(s1 + 1, s2);
        check("t1_idle_busy", 64'(bus.busy), 64'd0);

        do_reset();
        run_range(s2, s3);
        run_range(s3, s4a);

        run_range(s4a, s4b);
        bus.flush_req = 1'b1;
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            #1;
            check("flush_req_ready", 64'(bus.req_ready), 64'd0);
            check("flush_done", 64'(bus.flush_done), 64'(cyc >= last_res_cyc + 1));
            @(posedge clk);
            #2;
        end
        run_range(s4b, s6);

        run_range(s6, s5);

        run_range(s5, vecs.size());
        do_reset();
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #2;
        end
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_flush_done", 64'(bus.flush_done), 64'd0);
        check("t5_mul_a", 64'(bus.mul_a), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
